// File: rtl/color_core_sched.sv
// Round-robin dispatcher from one AXI-Stream task source to N_CORES ap_ctrl-style task cores.
// Optional SCHED_STATS_EN adds per-core dispatch counters and a global completion counter.
module color_core_sched #(
    parameter int unsigned N_CORES  = 4,
    parameter int unsigned TQ_WIDTH = 32
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [TQ_WIDTH-1:0]           s_task_TDATA,
    input  logic                          s_task_TVALID,
    output logic                          s_task_TREADY,
    input  logic                          pause,
    output logic [N_CORES-1:0]            core_ap_start,
    output logic [N_CORES*TQ_WIDTH-1:0]   core_task_in,
    input  logic [N_CORES-1:0]            core_ap_ready,
    input  logic [N_CORES-1:0]            core_ap_done,
    output logic [$clog2(N_CORES+1)-1:0]  n_busy,
    output logic                          all_idle,
    output logic [2*N_CORES-1:0]          sched_state
`ifdef SCHED_STATS_EN
    ,
    output logic [N_CORES*32-1:0]         stat_dispatched,
    output logic [31:0]                   stat_completed
`endif
);

    localparam int unsigned PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int unsigned CNT_W = $clog2(N_CORES + 1);

    typedef enum logic [1:0] {
        StFree  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2
    } state_e;

    state_e              r_state [N_CORES];
    logic [TQ_WIDTH-1:0] r_task  [N_CORES];
    logic [PTR_W-1:0]    r_ptr;
    logic                r_active;

    logic [N_CORES-1:0]  w_free;
    logic [N_CORES-1:0]  w_grant_oh;
    logic [PTR_W-1:0]    w_next_ptr;
    logic                w_fire;
    logic [CNT_W-1:0]    w_n_busy;
    logic [CNT_W-1:0]    w_n_done;

    always_comb begin
        w_n_busy = '0;
        w_n_done = '0;
        for (int i = 0; i < N_CORES; i++) begin
            w_free[i] = (r_state[i] == StFree);
            w_n_busy  = w_n_busy + CNT_W'(!w_free[i]);
            w_n_done  = w_n_done + CNT_W'((r_state[i] == StRun) && core_ap_done[i]);
        end
    end

    // r_active keeps TREADY low while reset is asserted and until the first clock after release
    assign s_task_TREADY = r_active && !pause && (|w_free);
    assign w_fire        = s_task_TVALID && s_task_TREADY;
    assign n_busy        = w_n_busy;
    assign all_idle      = &w_free;

    // Scan candidates starting at the pointer, wrapping modulo N_CORES; first FREE core wins
    always_comb begin
        logic             found;
        logic [PTR_W:0]   sum;
        logic [PTR_W:0]   nxt;
        logic [PTR_W-1:0] idx;
        found      = 1'b0;
        sum        = '0;
        nxt        = '0;
        idx        = '0;
        w_grant_oh = '0;
        w_next_ptr = r_ptr;
        for (int k = 0; k < N_CORES; k++) begin
            sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_CORES)) sum = sum - (PTR_W+1)'(N_CORES);
            idx = sum[PTR_W-1:0];
            if (!found && w_free[idx]) begin
                found           = 1'b1;
                w_grant_oh[idx] = 1'b1;
                nxt             = {1'b0, idx} + (PTR_W+1)'(1);
                if (nxt >= (PTR_W+1)'(N_CORES)) nxt = '0;
                w_next_ptr      = nxt[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_active <= 1'b0;
            r_ptr    <= '0;
            for (int i = 0; i < N_CORES; i++) begin
                r_state[i] <= StFree;
                r_task[i]  <= '0;
            end
        end else begin
            r_active <= 1'b1;
            if (w_fire) r_ptr <= w_next_ptr;
            for (int i = 0; i < N_CORES; i++) begin
                unique case (r_state[i])
                    StFree: begin
                        if (w_fire && w_grant_oh[i]) begin
                            r_state[i] <= StStart;
                            r_task[i]  <= s_task_TDATA;
                        end
                    end
                    StStart: if (core_ap_ready[i]) r_state[i] <= StRun;
                    StRun:   if (core_ap_done[i])  r_state[i] <= StFree;
                    default: r_state[i] <= StFree;
                endcase
            end
        end
    end

`ifdef SCHED_STATS_EN
    logic [31:0] r_disp [N_CORES];
    logic [31:0] r_comp;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_comp <= '0;
            for (int i = 0; i < N_CORES; i++) r_disp[i] <= '0;
        end else begin
            r_comp <= r_comp + 32'(w_n_done);
            for (int i = 0; i < N_CORES; i++) begin
                if (w_fire && w_grant_oh[i]) r_disp[i] <= r_disp[i] + 32'd1;
            end
        end
    end

    assign stat_completed = r_comp;
`endif

    for (genvar g = 0; g < N_CORES; g++) begin : g_out
        assign core_ap_start[g]                      = (r_state[g] == StStart);
        assign core_task_in[g*TQ_WIDTH +: TQ_WIDTH]  = r_task[g];
        assign sched_state[2*g +: 2]                 = r_state[g];
`ifdef SCHED_STATS_EN
        assign stat_dispatched[32*g +: 32]           = r_disp[g];
`endif
    end

endmodule

// File: tb/tb_color_core_sched.sv
// Directed bench for color_core_sched with N_CORES=4, TQ_WIDTH=32.
module tb_color_core_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned TW = 32;

    logic            ap_clk;
    logic            ap_rst_n;
    logic [TW-1:0]   s_task_TDATA;
    logic            s_task_TVALID;
    logic            s_task_TREADY;
    logic            pause;
    logic [N-1:0]    core_ap_start;
    logic [N*TW-1:0] core_task_in;
    logic [N-1:0]    core_ap_ready;
    logic [N-1:0]    core_ap_done;
    logic [2:0]      n_busy;
    logic            all_idle;
    logic [2*N-1:0]  sched_state;
`ifdef SCHED_STATS_EN
    logic [N*32-1:0] stat_dispatched;
    logic [31:0]     stat_completed;
`endif

    int n_chk = 0;
    int n_err = 0;

    color_core_sched #(.N_CORES(N), .TQ_WIDTH(TW)) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .s_task_TDATA  (s_task_TDATA),
        .s_task_TVALID (s_task_TVALID),
        .s_task_TREADY (s_task_TREADY),
        .pause         (pause),
        .core_ap_start (core_ap_start),
        .core_task_in  (core_task_in),
        .core_ap_ready (core_ap_ready),
        .core_ap_done  (core_ap_done),
        .n_busy        (n_busy),
        .all_idle      (all_idle),
        .sched_state   (sched_state)
`ifdef SCHED_STATS_EN
        ,
        .stat_dispatched (stat_dispatched),
        .stat_completed  (stat_completed)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001;
    localparam logic [31:0] A2 = 32'hA000_0002, A3 = 32'hA000_0003;
    localparam logic [31:0] TB = 32'hB000_000B, TC = 32'hC000_000C;
    localparam logic [31:0] TD = 32'hD000_000D, TE = 32'hE000_000E;
    localparam logic [31:0] TF = 32'hF000_000F, TG = 32'h6000_0006;

    initial begin
        ap_rst_n      = 1'b1;
        s_task_TDATA  = '0;
        s_task_TVALID = 1'b0;
        pause         = 1'b0;
        core_ap_ready = 4'b1011;
        core_ap_done  = 4'b0000;

        // Asynchronous reset before any clock edge
        #1 ap_rst_n = 1'b0;
        #2;
        check("rst_start",    core_ap_start, 4'b0000);
        check("rst_task_in",  core_task_in,  128'h0);
        check("rst_tready",   s_task_TREADY, 1'b0);
        check("rst_n_busy",   n_busy,        3'd0);
        check("rst_all_idle", all_idle,      1'b1);
        check("rst_state",    sched_state,   8'h00);
        tick();
        check("rst_tready_clk", s_task_TREADY, 1'b0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        tick();
        check("post_rst_tready", s_task_TREADY, 1'b1);

        // Round-robin fill: core 2 keeps ap_ready low
        s_task_TVALID = 1'b1;
        s_task_TDATA  = A0;
        settle();
        tick();
        s_task_TDATA = A1;
        settle();
        check("rr_g0_start", core_ap_start, 4'b0001);
        check("rr_g0_state", sched_state,   8'h01);
        tick();
        s_task_TDATA = A2;
        settle();
        check("rr_g1_state", sched_state, 8'h06);
        tick();
        s_task_TDATA = A3;
        settle();
        check("rr_g2_state", sched_state,   8'h1A);
        check("rr_g2_start", core_ap_start, 4'b0100);
        tick();
        s_task_TDATA = TB;
        settle();
        check("full_state",   sched_state,   8'h5A);
        check("full_tready",  s_task_TREADY, 1'b0);
        check("full_n_busy",  n_busy,        3'd4);
        check("full_idle",    all_idle,      1'b0);
        check("full_task_in", core_task_in,  {A3, A2, A1, A0});

        // Start hold on core 2
        for (int k = 0; k < 4; k++) begin
            tick();
            check("hold_start2", core_ap_start[2],   1'b1);
            check("hold_task2",  core_task_in[95:64], A2);
        end
        check("hold_state",   sched_state,  8'h9A);
        check("hold_no_samp", core_task_in, {A3, A2, A1, A0});
        core_ap_ready = 4'b1111;
        settle();
        check("hold_ready_state", sched_state, 8'h9A);
        tick();
        check("run_all_state", sched_state,   8'hAA);
        check("run_all_start", core_ap_start, 4'b0000);

        // Refill after done on core 1
        core_ap_done = 4'b0010;
        settle();
        check("done_no_comb_tready", s_task_TREADY, 1'b0);
        check("done_no_comb_busy",   n_busy,        3'd4);
        tick();
        core_ap_done = 4'b0000;
        settle();
        check("refill_tready", s_task_TREADY, 1'b1);
        check("refill_busy",   n_busy,        3'd3);
        tick();
        s_task_TVALID = 1'b0;
        settle();
        check("refill_start", core_ap_start,        4'b0010);
        check("refill_task1", core_task_in[63:32],  TB);
        tick();

        // Pause with two cores free
        core_ap_done = 4'b1001;
        tick();
        core_ap_done  = 4'b0000;
        pause         = 1'b1;
        s_task_TVALID = 1'b1;
        s_task_TDATA  = TC;
        settle();
        check("pause_tready", s_task_TREADY, 1'b0);
        check("pause_busy",   n_busy,        3'd2);
        check("pause_state",  sched_state,   8'h28);
        tick();
        tick();
        check("pause_no_grant", core_ap_start, 4'b0000);
        check("pause_busy2",    n_busy,        3'd2);
        core_ap_done = 4'b0110;
        tick();
        core_ap_done = 4'b0000;
        settle();
        check("pause_idle",      all_idle,      1'b1);
        check("pause_idle_busy", n_busy,        3'd0);
        check("pause_idle_rdy",  s_task_TREADY, 1'b0);
        pause = 1'b0;
        settle();
        check("unpause_tready", s_task_TREADY, 1'b1);

        // Resume at pointer 2, then wrap 3 -> 0
        tick();
        s_task_TDATA = TD;
        settle();
        check("resume_start", core_ap_start,       4'b0100);
        check("resume_task2", core_task_in[95:64], TC);
        tick();
        s_task_TDATA = TE;
        settle();
        check("ptr3_start", core_ap_start,         4'b1000);
        check("ptr3_task",  core_task_in[127:96],  TD);
        tick();
        s_task_TVALID = 1'b0;
        settle();
        check("wrap_start",   core_ap_start, 4'b0001);
        check("wrap_busy",    n_busy,        3'd3);
        check("wrap_task_in", core_task_in,  {TD, TC, TB, TE});
        tick();

        // Done on core 2 and grant to core 1 in the same cycle
        s_task_TVALID = 1'b1;
        s_task_TDATA  = TF;
        core_ap_done  = 4'b0100;
        tick();
        core_ap_done = 4'b0000;
        s_task_TDATA = TG;
        settle();
        check("simul_start",  core_ap_start, 4'b0010);
        check("simul_busy",   n_busy,        3'd3);
        check("simul_tready", s_task_TREADY, 1'b1);
        tick();
        s_task_TVALID = 1'b0;
        settle();
        check("simul_regrant", core_ap_start,       4'b0100);
        check("simul_task2",   core_task_in[95:64], TG);
        tick();

        // Reset mid-operation
        ap_rst_n = 1'b0;
        settle();
        check("midrst_idle",    all_idle,      1'b1);
        check("midrst_busy",    n_busy,        3'd0);
        check("midrst_task_in", core_task_in,  128'h0);
        check("midrst_tready",  s_task_TREADY, 1'b0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        tick();

`ifdef SCHED_STATS_EN
        check("stat_rst_comp", stat_completed, 32'd0);
        for (int i = 0; i < 10; i++) begin
            s_task_TVALID = 1'b1;
            s_task_TDATA  = 32'(i);
            tick();
            s_task_TVALID = 1'b0;
            tick();
            if (i < 7) begin
                core_ap_done = 4'(1 << (i % 4));
                tick();
                core_ap_done = 4'b0000;
            end
        end
        settle();
        check("stat_busy",      n_busy,         3'd3);
        check("stat_completed", stat_completed, 32'd7);
        check("stat_disp_sum",
              stat_dispatched[31:0] + stat_dispatched[63:32] +
              stat_dispatched[95:64] + stat_dispatched[127:96], 32'd10);
        check("stat_disp_all", stat_dispatched, {32'd2, 32'd2, 32'd3, 32'd3});
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/color_core_sched.md
Name: color_core_sched

Overview:
- Dispatches tasks from one AXI-Stream task source to N_CORES identical ap_ctrl-style task cores (e.g. color cores).
- Per-core handshake: ap_start / ap_ready / ap_done, with task_in held stable while the core is starting.
- Picks a free core round-robin and tracks each core's lifecycle.
- Reports occupancy so the task-queue front end can detect quiescence.

Parameters:
- N_CORES, 4, number of attached cores (1..16).
- TQ_WIDTH, chronos::TQ_WIDTH, width of one packed task word.
- PTR_W, $clog2(N_CORES) (min 1), round-robin pointer width.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- s_task_TDATA  in  TQ_WIDTH  incoming task
- s_task_TVALID  in  1  task valid
- s_task_TREADY  out  1  scheduler accepts task this cycle
- pause  in  1  when 1, no new task is accepted; in-flight tasks complete normally
- core_ap_start  out  N_CORES  per-core start
- core_task_in  out  N_CORES*TQ_WIDTH  per-core task word; slice i belongs to core i
- core_ap_ready  in  N_CORES  per-core ready (core is in its fetch state)
- core_ap_done  in  N_CORES  per-core done pulse
- n_busy  out  $clog2(N_CORES+1)  number of cores not FREE
- all_idle  out  1  all cores FREE
- sched_state  out  2*N_CORES  per-core FSM encodings, for debug

Behaviour:
- Reset is asynchronous, active-low; every flop clears on ap_rst_n=0 regardless of the clock.
- Reset values:
  - core_ap_start=0, core_task_in=0, s_task_TREADY=0.
  - n_busy=0, all_idle=1.
  - Round-robin pointer=0, all core FSMs FREE.
- Reset mid-operation abandons in-flight tasks; the system reset also resets the cores.
- Per-core FSM, encodings FREE=0, START=1, RUN=2:
  - FREE -> START when the task is granted to this core; task_in[i] is loaded the same edge.
  - START: core_ap_start[i]=1 and task_in[i] is held. Goes to RUN in the cycle core_ap_ready[i]=1 (start&ready is the accept point).
  - RUN -> FREE on core_ap_done[i]=1.
  - core_ap_done in FREE or START is ignored.
- s_task_TREADY = !pause & (any core FREE), computed combinationally from registered FSM state.
- Grant rule:
  - When TVALID&TREADY, grant the lowest-index FREE core at or above the pointer, wrapping modulo N_CORES.
  - After a grant to core i, pointer <= (i+1) mod N_CORES. Without a grant the pointer holds.
  - At most one grant per cycle.
- Latency:
  - A task accepted at edge t gives core_ap_start high from cycle t+1.
  - With ap_ready already high, the core accepts at t+1 and its FSM reaches RUN at t+2.
- Simultaneous events:
  - If ap_done[i] and TVALID arrive in the same cycle, core i is not eligible that cycle; it becomes FREE at the next edge and is grantable one cycle later.
  - Done on core j and grant to core k in the same cycle are independent.
- Full: all cores non-FREE -> TREADY=0 and TDATA is not sampled.
- Empty: all_idle=1 and n_busy=0 only when every FSM is FREE; both are registered-state derived, with no combinational path from ap_done.
- n_busy is the popcount of non-FREE cores and equals N_CORES when full.
- core_task_in slices of FREE cores keep their last value.

Optional Feature:
- Macro: SCHED_STATS_EN.
- When defined, adds output port stat_dispatched (N_CORES*32) and output stat_completed (32).
  - stat_dispatched holds per-core grant counters; stat_completed counts RUN->FREE transitions.
  - Counters wrap at 2^32 and clear on reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: hold ap_rst_n=0 with no clock edges -> outputs at reset values immediately; all_idle=1, TREADY=0. After release with pause=0 -> TREADY=1.
- Round-robin, N_CORES=4, all cores ready and never done: 4 tasks on consecutive cycles -> granted to cores 0,1,2,3; then TREADY=0, n_busy=4; task_in slices equal the tasks sent.
- Start hold: core 2 ap_ready held low for 5 cycles after grant -> core_ap_start[2] stays 1 and task_in[2] is stable for 5 cycles; RUN is entered on the cycle ready rises.
- Full and refill: all busy, TVALID=1; pulse done on core 1 -> TREADY rises next cycle and the task is granted to core 1; the pointer advances to 2.
- Pause: pause=1 with TVALID=1 and 2 cores free -> no grants and TREADY=0. Running cores finish, giving all_idle=1. Deassert pause -> grant resumes at the pointer.
- SCHED_STATS_EN: dispatch 10 tasks and complete 7 -> sum of stat_dispatched=10, stat_completed=7, n_busy=3.
